// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_pkg
// Brief    : Shared types and constants for the instruction fetch buffer.
// Revision : 1.0 - initial release
// ============================================================================
package ifetch_pkg;

    localparam int LINE_W  = 64;
    localparam int INSTR_W = 32;

    // Fetch controller states
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // One queued SRAM line: data, line address [31:3] and the epoch it was fetched in
    typedef struct packed {
        logic [LINE_W-1:0] line;
        logic [28:0]       line_pc;
        logic              epoch;
    } ifb_entry_t;

    // Pick the 32-bit instruction out of a line by pc[2]
    function automatic logic [INSTR_W-1:0] select_half(input logic [LINE_W-1:0] line,
                                                       input logic half);
        return half ? line[63:32] : line[31:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ifb_line_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ifb_line_fifo
// Brief    : DEPTH-entry line queue with push/pop, occupancy count and flush.
// Revision : 1.0 - initial release
// ============================================================================
module ifb_line_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PTRW  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            push,
    input  ifb_entry_t      wr_entry,
    input  logic            pop,
    output ifb_entry_t      rd_entry,
    output logic [PTRW:0]   count,
    output logic            full,
    output logic            empty
);

    ifb_entry_t      mem [DEPTH];
    logic [PTRW-1:0] wr_ptr;
    logic [PTRW-1:0] rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (PTRW+1)'(DEPTH));
    // Flush wins over any same-cycle push or pop; a push into a full queue
    // is only accepted when a pop frees the slot in the same cycle.
    assign do_pop   = pop && !flush && !empty;
    assign do_push  = push && !flush && (!full || do_pop);
    assign rd_entry = mem[rd_ptr];

    // Line storage write at the tail
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // Pointer and occupancy tracking; pointers wrap modulo DEPTH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTRW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTRW'(1);
            count <= count + (PTRW+1)'(do_push) - (PTRW+1)'(do_pop);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ifetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_buffer
// Brief    : Instruction fetch front end: issues 64-bit SRAM line reads,
//            queues returned lines and hands 32-bit instructions plus PC to
//            decode over valid/ready. Handles boot start and redirects.
//            Optional macro IFB_BYPASS_EN forwards returning read data
//            straight to the outputs when the queue is empty.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_buffer
#(
    parameter int DEPTH = 2,
    parameter int PTRW  = 1
) (
    input  logic        clk,
    input  logic        cpurst_n,
    input  logic [31:0] boot_addr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        isram_cs,
    output logic [28:0] isram_adr,
    input  logic [63:0] isram_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);
    import ifetch_pkg::*;

    state_t          state;
    logic [28:0]     fetch_line;     // next line to request (fetch_pc[31:3])
    logic            inflight;       // read data is on isram_rdata this cycle
    logic            inflight_epoch;
    logic [28:0]     inflight_line;
    logic            epoch;
    logic            half;           // pc[2] of the instruction at the head

    ifb_entry_t      head_entry;
    ifb_entry_t      wr_entry;
    logic [PTRW:0]   q_count;
    logic            q_full;
    logic            q_empty;

    logic            redirect;
    logic            data_ok;
    logic            head_ok;
    logic            bypass;
    logic [63:0]     src_line;
    logic [28:0]     src_pc;
    logic            fire;
    logic            consume;
    logic            line_done;
    logic            push;
    logic            pop;
    logic [PTRW+1:0] used;
    logic            issue;
    logic            unused_ok;

    assign redirect = redirect_valid && (state != ST_BOOT);
    // Data from a read issued before the latest redirect carries the old epoch
    assign data_ok  = inflight && (inflight_epoch == epoch);
    assign head_ok  = !q_empty && (head_entry.epoch == epoch);

`ifdef IFB_BYPASS_EN
    assign bypass = q_empty && data_ok;
`else
    assign bypass = 1'b0;
`endif

    assign src_line    = bypass ? isram_rdata   : head_entry.line;
    assign src_pc      = bypass ? inflight_line : head_entry.line_pc;
    assign instr_valid = head_ok || bypass;
    assign instr       = instr_valid ? select_half(src_line, half) : '0;
    assign instr_pc    = instr_valid ? {src_pc, half, 2'b00} : '0;

    // A redirect discards the presented instruction along with the queue
    assign fire      = instr_valid && instr_ready;
    assign consume   = fire && !redirect;
    assign line_done = consume && half;
    assign pop       = line_done && head_ok;
    // A line fully consumed through the bypass never needs a queue slot
    assign push      = data_ok && !redirect && !(bypass && line_done);
    assign wr_entry  = '{line: isram_rdata, line_pc: inflight_line, epoch: epoch};

    // Credit: queued lines plus both read pipeline stages, less the line
    // leaving this cycle, so the queue can never be oversubscribed.
    assign used  = (PTRW+2)'(q_count) + (PTRW+2)'(isram_cs)
                 + (PTRW+2)'(inflight) - (PTRW+2)'(line_done);
    assign issue = (state != ST_BOOT) && !redirect && (used < (PTRW+2)'(DEPTH));

    assign unused_ok = ^{boot_addr[1:0], redirect_pc[1:0], q_full};

    ifb_line_fifo #(
        .DEPTH (DEPTH),
        .PTRW  (PTRW)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (cpurst_n),
        .flush    (redirect),
        .push     (push),
        .wr_entry (wr_entry),
        .pop      (pop),
        .rd_entry (head_entry),
        .count    (q_count),
        .full     (q_full),
        .empty    (q_empty)
    );

    // Fetch state machine, SRAM request issue and read-return tracking
    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            state          <= ST_BOOT;
            fetch_line     <= '0;
            isram_cs       <= 1'b0;
            isram_adr      <= '0;
            inflight       <= 1'b0;
            inflight_epoch <= 1'b0;
            inflight_line  <= '0;
            epoch          <= 1'b0;
            half           <= 1'b0;
        end else begin
            isram_cs       <= issue;
            inflight       <= isram_cs;
            inflight_epoch <= epoch;
            inflight_line  <= isram_adr;
            case (state)
                ST_BOOT: begin
                    fetch_line <= boot_addr[31:3];
                    half       <= boot_addr[2];
                    state      <= ST_RUN;
                end
                default: begin
                    if (redirect) begin
                        fetch_line <= redirect_pc[31:3];
                        half       <= redirect_pc[2];
                        epoch      <= ~epoch;
                        state      <= ST_FLUSH;
                    end else begin
                        state <= ST_RUN;
                        if (issue) begin
                            isram_adr  <= fetch_line;
                            fetch_line <= fetch_line + 29'd1;
                        end
                        if (consume) begin
                            half <= ~half;
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch_buffer
// Brief    : Directed self-checking bench for ifetch_buffer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch_buffer;

`ifdef IFB_BYPASS_EN
    localparam int LAG = 0;
`else
    localparam int LAG = 1;
`endif

    logic        clk = 1'b0;
    logic        cpurst_n = 1'b1;
    logic [31:0] boot_addr = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        isram_cs;
    logic [28:0] isram_adr;
    logic [63:0] isram_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b1;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int errors = 0;
    int checks = 0;

    ifetch_buffer #(.DEPTH(2), .PTRW(1)) dut (
        .clk            (clk),
        .cpurst_n       (cpurst_n),
        .boot_addr      (boot_addr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .isram_cs       (isram_cs),
        .isram_adr      (isram_adr),
        .isram_rdata    (isram_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    // Instruction word stored at a given byte address
    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return pc ^ 32'h5A3C_0F00;
    endfunction

    // SRAM model: data one cycle after cs, junk otherwise
    always @(posedge clk) begin
        if (isram_cs)
            isram_rdata <= {word_at({isram_adr, 3'b100}), word_at({isram_adr, 3'b000})};
        else
            isram_rdata <= 64'hDEAD_BEEF_0BAD_F00D;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [31:0] baddr);
        cpurst_n       = 1'b0;
        boot_addr      = baddr;
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;
        tick();
        tick();
        cpurst_n = 1'b1;
    endtask

    // Follow a sequential fetch stream from pc0 with ready held high.
    // Reports the cycle of first read data and of first instr_valid.
    task automatic run_stream(input string tag, input logic [31:0] pc0, input int ncyc,
                              output int data_cyc, output int valid_cyc);
        logic [28:0] exp_adr;
        logic [31:0] exp_pc;
        logic        prev_cs;
        exp_adr   = pc0[31:3];
        exp_pc    = pc0;
        prev_cs   = 1'b0;
        data_cyc  = -1;
        valid_cyc = -1;
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            if (prev_cs && data_cyc < 0) data_cyc = c;
            if (isram_cs) begin
                check({tag, " cs adr"}, {3'b0, isram_adr}, {3'b0, exp_adr});
                exp_adr = exp_adr + 29'd1;
            end
            if (valid_cyc >= 0) check({tag, " no bubble"}, {31'b0, instr_valid}, 32'd1);
            if (instr_valid) begin
                if (valid_cyc < 0) valid_cyc = c;
                check({tag, " instr_pc"}, instr_pc, exp_pc);
                check({tag, " instr"}, instr, word_at(exp_pc));
                exp_pc = exp_pc + 32'd4;
            end
            prev_cs = isram_cs;
        end
        check({tag, " stream started"}, {31'b0, (valid_cyc >= 0)}, 32'd1);
    endtask

    initial begin
        int d;
        int v;
        int cs_cnt;
        int first_cs;
        logic found;
        logic [31:0] exp_pc;
        logic [28:0] exp_adr;

        // Reset values
        #2 cpurst_n = 1'b0;
        #1;
        check("rst cs", {31'b0, isram_cs}, 32'd0);
        check("rst adr", {3'b0, isram_adr}, 32'd0);
        check("rst valid", {31'b0, instr_valid}, 32'd0);
        check("rst instr", instr, 32'd0);
        check("rst pc", instr_pc, 32'd0);

        // 1: boot at 0x80, streaming
        do_reset(32'h80);
        run_stream("t1", 32'h80, 30, d, v);
        check("t1 first valid cycle", 32'(v), 32'(3 + LAG));
        check("t1 data-to-valid lag", 32'(v - d), 32'(LAG));

        // 2: boot at 0x84 starts at upper half
        do_reset(32'h84);
        run_stream("t2", 32'h84, 12, d, v);
        check("t2 first valid cycle", 32'(v), 32'(3 + LAG));

        // 3: decode stalled for 10 cycles
        do_reset(32'h80);
        instr_ready = 1'b0;
        cs_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (isram_cs) cs_cnt++;
        end
        check("t3 lines fetched", 32'(cs_cnt), 32'd2);
        check("t3 cs idle", {31'b0, isram_cs}, 32'd0);
        check("t3 held valid", {31'b0, instr_valid}, 32'd1);
        check("t3 held pc", instr_pc, 32'h80);
        instr_ready = 1'b1;
        exp_pc   = 32'h84;
        exp_adr  = 29'h12;
        first_cs = -1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check("t3 drain valid", {31'b0, instr_valid}, 32'd1);
            check("t3 drain pc", instr_pc, exp_pc);
            exp_pc = exp_pc + 32'd4;
            if (isram_cs) begin
                if (first_cs < 0) first_cs = k;
                check("t3 resume adr", {3'b0, isram_adr}, {3'b0, exp_adr});
                exp_adr = exp_adr + 29'd1;
            end
        end
        check("t3 resume cycle", 32'(first_cs), 32'd2);

        // 4: redirect to 0x203 with a read inflight and a handshake this cycle
        do_reset(32'h80);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (isram_cs && instr_valid) begin
                found = 1'b1;
                break;
            end
        end
        check("t4 inflight+handshake found", {31'b0, found}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        tick();
        redirect_valid = 1'b0;
        check("t4 flush valid", {31'b0, instr_valid}, 32'd0);
        check("t4 flush cs", {31'b0, isram_cs}, 32'd0);
        run_stream("t4", 32'h200, 14, d, v);
        check("t4 data cycle", 32'(d), 32'd2);
        check("t4 data-to-valid lag", 32'(v - d), 32'(LAG));

        // 5: asynchronous reset mid-stream, restart from new boot address
        do_reset(32'h80);
        for (int i = 0; i < 6; i++) tick();
        check("t5 pre-reset valid", {31'b0, instr_valid}, 32'd1);
        cpurst_n = 1'b0;
        #1;
        check("t5 async cs", {31'b0, isram_cs}, 32'd0);
        check("t5 async adr", {3'b0, isram_adr}, 32'd0);
        check("t5 async valid", {31'b0, instr_valid}, 32'd0);
        check("t5 async instr", instr, 32'd0);
        check("t5 async pc", instr_pc, 32'd0);
        boot_addr = 32'h100;
        tick();
        cpurst_n = 1'b1;
        run_stream("t5", 32'h100, 12, d, v);
        check("t5 first valid cycle", 32'(v), 32'(3 + LAG));

        // Address wrap at the top of the address space
        do_reset(32'hFFFF_FFF8);
        run_stream("wrap", 32'hFFFF_FFF8, 16, d, v);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
